// File: rtl/yuyv_frame_ctrl_pkg.sv
// Shared types for the YUYV frame sequencer.
// Holds the FSM state encoding, default frame geometry and the sideband marker bundle.
package yuyv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    localparam int DEF_IMG_WIDTH  = 320;
    localparam int DEF_IMG_HEIGHT = 466;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } marker_t;

endpackage

// File: rtl/yuyv_frame_ctrl_if.sv
// Pixel-pair stream between the capture FIFO, the sequencer and the converter,
// plus the credit-return strobe from the downstream RGB FIFO.
interface yuyv_frame_ctrl_if;

    logic        src_empty;
    logic [31:0] src_data;
    logic        src_rd_en;
    logic        cvt_valid;
    logic [31:0] cvt_data;
    logic        sink_pop;

    modport master (
        input  src_empty,
        input  src_data,
        input  sink_pop,
        output src_rd_en,
        output cvt_valid,
        output cvt_data
    );

    modport slave (
        output src_empty,
        output src_data,
        output sink_pop,
        input  src_rd_en,
        input  cvt_valid,
        input  cvt_data
    );

endinterface

// File: rtl/yuyv_frame_ctrl_sideband_delay.sv
// Fixed-depth register chain that carries frame markers alongside the converter pipeline.
module sideband_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/yuyv_frame_ctrl.sv
// Frame sequencer feeding YUYV pixel pairs to the RGB converter under credit flow control,
// generating SOF/EOL/EOF markers aligned to the converter output.
module yuyv_frame_ctrl
    import yuyv_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIPE_LAT   = 3,
    parameter int CREDITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    abort,
    yuyv_frame_ctrl_if.master       bus,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic [9:0]              x_pos,
    output logic [9:0]              y_pos,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    aborted,
    output logic                    credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int DW = $clog2(PIPE_LAT + 2);

    ctrl_state_t   state;
    logic [9:0]    x_cnt;
    logic [9:0]    y_cnt;
    logic [CW-1:0] credit;
    logic [DW-1:0] drain_cnt;
    logic          issue;
    logic          at_eol;
    logic          last_pair;
    marker_t       mark_now;
    marker_t       mark_q;
    marker_t       mark_out;

    // x_cnt/y_cnt always name the pair about to be issued.
    assign at_eol    = (x_cnt == 10'(IMG_WIDTH - 2));
    assign last_pair = at_eol && (y_cnt == 10'(IMG_HEIGHT - 1));
    assign issue     = (state == RUN) && !bus.src_empty && (credit != '0) && !abort;
    assign bus.src_rd_en = issue;
    assign busy      = (state != IDLE);

    always_comb begin
        mark_now     = '0;
        mark_now.sof = issue && (x_cnt == 10'd0) && (y_cnt == 10'd0);
        mark_now.eol = issue && at_eol;
        mark_now.eof = issue && last_pair;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            x_pos         <= '0;
            y_pos         <= '0;
            bus.cvt_valid <= 1'b0;
            bus.cvt_data  <= '0;
            mark_q        <= '0;
            drain_cnt     <= '0;
            frame_done    <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            bus.cvt_valid <= issue;
            mark_q        <= mark_now;
            frame_done    <= 1'b0;
            if (issue) begin
                bus.cvt_data <= bus.src_data;
                x_pos        <= x_cnt;
                y_pos        <= y_cnt;
                if (at_eol) begin
                    x_cnt <= '0;
                    y_cnt <= last_pair ? 10'd0 : y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd2;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        aborted <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted   <= 1'b1;
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else if (issue && last_pair) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // frame_done is raised on the last DRAIN cycle, once the final markers are out.
                    if (frame_done) begin
                        if (continuous && !aborted) begin
                            state <= RUN;
                            x_cnt <= '0;
                            y_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (drain_cnt == DW'(PIPE_LAT)) begin
                        frame_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A pop at full credit with no concurrent issue is a protocol error; the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit     <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            credit_err <= 1'b0;
            if (issue && !bus.sink_pop) begin
                credit <= credit - CW'(1);
            end else if (!issue && bus.sink_pop) begin
                if (credit == CW'(CREDITS)) begin
                    credit_err <= 1'b1;
                end else begin
                    credit <= credit + CW'(1);
                end
            end
        end
    end

    sideband_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (3)
    ) u_marker_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (mark_q),
        .dout (mark_out)
    );

    assign out_sof = mark_out.sof;
    assign out_eol = mark_out.eol;
    assign out_eof = mark_out.eof;

endmodule

// File: tb/tb_yuyv_frame_ctrl.sv
// Directed testbench for yuyv_frame_ctrl on a 4x2 frame: a CREDITS=8 instance for frame
// behaviour and a CREDITS=2 instance for credit flow control.
module tb_yuyv_frame_ctrl;
    import yuyv_ctrl_pkg::*;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int LAT = 3;
    localparam logic [31:0] BASE = 32'hA500_0000;

    logic clk = 1'b0;
    logic rst;
    logic start, continuous, abort, start2;
    logic auto_pop, pop_man, pop2;
    logic sof, eol, eof, busy, frame_done, aborted, credit_err;
    logic [9:0] x_pos, y_pos;
    logic sof2, eol2, eof2, busy2, frame_done2, aborted2, credit_err2;
    logic [9:0] x_pos2, y_pos2;
    logic [LAT-1:0] cv_pipe;
    logic out_valid;

    int tests, fails;
    int cyc, rd_cnt, rd2_cnt, fd_cnt, fd_cyc, stray, cerr_cnt, cerr2_cnt, busy_low;
    int first_valid_cyc, last_valid_cyc, src_idx, base_idx;
    logic [31:0] data_q [$];
    logic [2:0]  mark_q [$];
    int          out_cyc_q [$];
    logic [19:0] pos_q [$];
    logic [2:0]  exp_mark [4];

    yuyv_frame_ctrl_if bus ();
    yuyv_frame_ctrl_if bus2 ();

    yuyv_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(LAT), .CREDITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .bus(bus), .out_sof(sof), .out_eol(eol), .out_eof(eof),
        .x_pos(x_pos), .y_pos(y_pos), .busy(busy), .frame_done(frame_done),
        .aborted(aborted), .credit_err(credit_err)
    );

    yuyv_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(LAT), .CREDITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .continuous(1'b0), .abort(1'b0),
        .bus(bus2), .out_sof(sof2), .out_eol(eol2), .out_eof(eof2),
        .x_pos(x_pos2), .y_pos(y_pos2), .busy(busy2), .frame_done(frame_done2),
        .aborted(aborted2), .credit_err(credit_err2)
    );

    always #5 clk = ~clk;

    // Stand-in for the converter's valid pipeline; its output doubles as the downstream pop.
    always @(posedge clk or posedge rst) begin
        if (rst) cv_pipe <= '0;
        else     cv_pipe <= {cv_pipe[LAT-2:0], bus.cvt_valid};
    end
    assign out_valid     = cv_pipe[LAT-1];
    assign bus.sink_pop  = auto_pop ? out_valid : pop_man;
    assign bus2.sink_pop = pop2;

    task automatic clear();
        rd_cnt = 0; rd2_cnt = 0; fd_cnt = 0; fd_cyc = 0; stray = 0;
        cerr_cnt = 0; cerr2_cnt = 0; busy_low = 0;
        first_valid_cyc = -1; last_valid_cyc = -1; base_idx = src_idx;
        data_q.delete(); mark_q.delete(); out_cyc_q.delete(); pos_q.delete();
    endtask

    task automatic tick();
        logic popped;
        #1;
        popped = bus.src_rd_en;
        if (bus.src_rd_en) rd_cnt++;
        if (bus2.src_rd_en) rd2_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (popped) begin
            src_idx++;
            bus.src_data = BASE + 32'(src_idx);
        end
        if (bus.cvt_valid) begin
            data_q.push_back(bus.cvt_data);
            pos_q.push_back({x_pos, y_pos});
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
        end
        if (out_valid) begin
            mark_q.push_back({sof, eol, eof});
            out_cyc_q.push_back(cyc);
        end else if (sof || eol || eof) begin
            stray++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (credit_err) cerr_cnt++;
        if (credit_err2) cerr2_cnt++;
        if (!busy) busy_low++;
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.cvt_valid, bus.cvt_data, sof, eol, eof, x_pos, y_pos, busy, frame_done, aborted, credit_err} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {bus.cvt_valid, bus.cvt_data, sof, eol, eof, x_pos, y_pos, busy, frame_done, aborted, credit_err});
        end
        tests++;
        if ({bus2.cvt_valid, sof2, eol2, eof2, x_pos2, y_pos2, busy2, frame_done2, aborted2, credit_err2} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs2: got %h expected 0", {bus2.cvt_valid, sof2, eol2, eof2, x_pos2, y_pos2, busy2, frame_done2, aborted2, credit_err2});
        end
        tests++;
        if (bus.src_rd_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.src_rd_en);
        end
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if ({busy, bus.cvt_valid, rd_cnt[0]} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy, bus.cvt_valid, rd_cnt[0]});
        end
    endtask

    task automatic test_single_frame();
        clear();
        auto_pop = 1'b1;
        bus.src_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && fd_cnt == 0; i++) tick();
        repeat (2) tick();
        tests++;
        if (fd_cnt !== 1) begin fails++; $display("[TB] FAIL single_frame_done: got %0d expected 1", fd_cnt); end
        tests++;
        if (rd_cnt !== 4) begin fails++; $display("[TB] FAIL single_issue_count: got %0d expected 4", rd_cnt); end
        tests++;
        if (last_valid_cyc - first_valid_cyc !== 3) begin
            fails++; $display("[TB] FAIL single_back_to_back: got span %0d expected 3", last_valid_cyc - first_valid_cyc);
        end
        tests++;
        if (data_q.size() !== 4) begin fails++; $display("[TB] FAIL single_data_count: got %0d expected 4", data_q.size()); end
        for (int i = 0; i < data_q.size() && i < 4; i++) begin
            tests++;
            if (data_q[i] !== BASE + 32'(base_idx + i)) begin
                fails++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, data_q[i], BASE + 32'(base_idx + i));
            end
            tests++;
            if (pos_q[i] !== {10'(2 * (i % 2)), 10'(i / 2)}) begin
                fails++; $display("[TB] FAIL single_pos[%0d]: got %h expected %h", i, pos_q[i], {10'(2 * (i % 2)), 10'(i / 2)});
            end
        end
        tests++;
        if (mark_q.size() !== 4) begin fails++; $display("[TB] FAIL single_marker_count: got %0d expected 4", mark_q.size()); end
        for (int i = 0; i < mark_q.size() && i < 4; i++) begin
            tests++;
            if (mark_q[i] !== exp_mark[i]) begin
                fails++; $display("[TB] FAIL single_marker[%0d]: got %b expected %b", i, mark_q[i], exp_mark[i]);
            end
        end
        tests++;
        if (stray !== 0) begin fails++; $display("[TB] FAIL single_stray_markers: got %0d expected 0", stray); end
        tests++;
        if (fd_cyc - last_valid_cyc !== LAT + 1) begin
            fails++; $display("[TB] FAIL single_done_latency: got %0d expected %0d", fd_cyc - last_valid_cyc, LAT + 1);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL single_back_to_idle: got %b expected 0", busy); end
    endtask

    task automatic test_credit_err();
        clear();
        auto_pop = 1'b0;
        pop_man = 1'b1;
        pop2 = 1'b1;
        tick();
        pop_man = 1'b0;
        pop2 = 1'b0;
        tests++;
        if ({credit_err, credit_err2} !== 2'b11) begin
            fails++; $display("[TB] FAIL credit_err_pulse: got %b expected 11", {credit_err, credit_err2});
        end
        tick();
        tests++;
        if ({credit_err, credit_err2, cerr_cnt[1:0]} !== 4'b0001) begin
            fails++; $display("[TB] FAIL credit_err_one_cycle: got %b expected 0001", {credit_err, credit_err2, cerr_cnt[1:0]});
        end
        auto_pop = 1'b1;
    endtask

    task automatic test_credit_stall();
        clear();
        bus2.src_empty = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (6) tick();
        tests++;
        if (rd2_cnt !== 2) begin fails++; $display("[TB] FAIL stall_issue_count: got %0d expected 2", rd2_cnt); end
        tests++;
        if (bus2.src_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL stall_rd_en: got %b expected 0", bus2.src_rd_en); end
        pop2 = 1'b1;
        tick();
        pop2 = 1'b0;
        repeat (4) tick();
        tests++;
        if (rd2_cnt !== 3) begin fails++; $display("[TB] FAIL stall_one_credit: got %0d expected 3", rd2_cnt); end
        // First pop lifts the count to 1; second pop coincides with the final issue.
        pop2 = 1'b1;
        repeat (2) tick();
        pop2 = 1'b0;
        repeat (8) tick();
        tests++;
        if ({rd2_cnt[2:0], busy2} !== 4'b1000) begin
            fails++; $display("[TB] FAIL stall_frame_end: got %b expected 1000", {rd2_cnt[2:0], busy2});
        end
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (5) tick();
        tests++;
        if (rd2_cnt !== 5) begin fails++; $display("[TB] FAIL stall_simultaneous_held: got %0d expected 5", rd2_cnt); end
    endtask

    task automatic test_starvation();
        clear();
        auto_pop = 1'b1;
        bus.src_empty = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.src_empty = 1'b0;
        tick();
        bus.src_empty = 1'b1;
        repeat (5) tick();
        tests++;
        if (rd_cnt !== 1) begin fails++; $display("[TB] FAIL starve_no_issue: got %0d expected 1", rd_cnt); end
        tests++;
        if ({x_pos, y_pos, bus.cvt_valid, bus.src_rd_en} !== 22'd0) begin
            fails++; $display("[TB] FAIL starve_pos_held: got %h expected 0", {x_pos, y_pos, bus.cvt_valid, bus.src_rd_en});
        end
        bus.src_empty = 1'b0;
        for (int i = 0; i < 30 && fd_cnt == 0; i++) tick();
        repeat (2) tick();
        tests++;
        if (rd_cnt !== 4 || fd_cnt !== 1) begin
            fails++; $display("[TB] FAIL starve_resume: got issues %0d done %0d expected 4 1", rd_cnt, fd_cnt);
        end
        tests++;
        if (mark_q.size() !== 4) begin fails++; $display("[TB] FAIL starve_marker_count: got %0d expected 4", mark_q.size()); end
        for (int i = 0; i < mark_q.size() && i < 4; i++) begin
            tests++;
            if (mark_q[i] !== exp_mark[i]) begin
                fails++; $display("[TB] FAIL starve_marker[%0d]: got %b expected %b", i, mark_q[i], exp_mark[i]);
            end
        end
        tests++;
        if (stray !== 0) begin fails++; $display("[TB] FAIL starve_stray_markers: got %0d expected 0", stray); end
    endtask

    task automatic test_continuous();
        clear();
        auto_pop = 1'b1;
        bus.src_empty = 1'b0;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 80 && fd_cnt < 2; i++) begin
            tick();
            if (fd_cnt == 1 && rd_cnt > 4) continuous = 1'b0;
        end
        tests++;
        if (busy_low !== 0) begin fails++; $display("[TB] FAIL cont_busy_held: got %0d idle cycles expected 0", busy_low); end
        repeat (3) tick();
        tests++;
        if (fd_cnt !== 2 || rd_cnt !== 8) begin
            fails++; $display("[TB] FAIL cont_two_frames: got done %0d issues %0d expected 2 8", fd_cnt, rd_cnt);
        end
        tests++;
        if (mark_q.size() !== 8) begin fails++; $display("[TB] FAIL cont_marker_count: got %0d expected 8", mark_q.size()); end
        for (int i = 0; i < mark_q.size() && i < 8; i++) begin
            tests++;
            if (mark_q[i] !== exp_mark[i % 4]) begin
                fails++; $display("[TB] FAIL cont_marker[%0d]: got %b expected %b", i, mark_q[i], exp_mark[i % 4]);
            end
        end
        if (out_cyc_q.size() >= 5) begin
            tests++;
            if (out_cyc_q[4] - out_cyc_q[3] !== LAT + 3) begin
                fails++; $display("[TB] FAIL cont_sof_after_eof: got gap %0d expected %0d", out_cyc_q[4] - out_cyc_q[3], LAT + 3);
            end
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL cont_idle_at_end: got %b expected 0", busy); end
    endtask

    task automatic test_abort();
        clear();
        auto_pop = 1'b1;
        bus.src_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        abort = 1'b1;
        #1;
        tests++;
        if (bus.src_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL abort_gates_issue: got %b expected 0", bus.src_rd_en); end
        tick();
        abort = 1'b0;
        for (int i = 0; i < 30 && fd_cnt == 0; i++) tick();
        repeat (2) tick();
        tests++;
        if (rd_cnt !== 2) begin fails++; $display("[TB] FAIL abort_issue_count: got %0d expected 2", rd_cnt); end
        tests++;
        if ({aborted, busy, fd_cnt[1:0]} !== 4'b1001) begin
            fails++; $display("[TB] FAIL abort_status: got %b expected 1001", {aborted, busy, fd_cnt[1:0]});
        end
        tests++;
        if (mark_q.size() !== 2 || stray !== 0) begin
            fails++; $display("[TB] FAIL abort_marker_count: got %0d stray %0d expected 2 0", mark_q.size(), stray);
        end
        for (int i = 0; i < mark_q.size() && i < 2; i++) begin
            tests++;
            if (mark_q[i] !== exp_mark[i]) begin
                fails++; $display("[TB] FAIL abort_marker[%0d]: got %b expected %b", i, mark_q[i], exp_mark[i]);
            end
        end
        // Start with a coincident abort in IDLE: start wins and clears the sticky flag.
        clear();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tests++;
        if ({busy, aborted} !== 2'b10) begin fails++; $display("[TB] FAIL restart_clears_aborted: got %b expected 10", {busy, aborted}); end
        for (int i = 0; i < 30 && fd_cnt == 0; i++) tick();
        repeat (2) tick();
        tests++;
        if (rd_cnt !== 4 || fd_cnt !== 1 || busy !== 1'b0) begin
            fails++; $display("[TB] FAIL restart_full_frame: got issues %0d done %0d busy %b expected 4 1 0", rd_cnt, fd_cnt, busy);
        end
    endtask

    task automatic test_reset_midframe();
        clear();
        auto_pop = 1'b1;
        bus.src_empty = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        tests++;
        if (x_pos !== 10'd2) begin fails++; $display("[TB] FAIL midframe_pos: got %0d expected 2", x_pos); end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.cvt_valid, bus.cvt_data, sof, eol, eof, x_pos, y_pos, busy, frame_done, aborted, credit_err, bus.src_rd_en} !== '0) begin
            fails++;
            $display("[TB] FAIL midframe_reset_outputs: got %h expected 0", {bus.cvt_valid, bus.cvt_data, sof, eol, eof, x_pos, y_pos, busy, frame_done, aborted, credit_err, bus.src_rd_en});
        end
        tick();
        tests++;
        if ({bus.cvt_valid, sof, eol, eof, busy, busy2} !== 6'd0) begin
            fails++; $display("[TB] FAIL midframe_reset_held: got %b expected 0", {bus.cvt_valid, sof, eol, eof, busy, busy2});
        end
        rst = 1'b0;
        repeat (8) tick();
        tests++;
        if (fd_cnt !== 0 || busy !== 1'b0) begin
            fails++; $display("[TB] FAIL midframe_no_done: got done %0d busy %b expected 0 0", fd_cnt, busy);
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; src_idx = 0;
        exp_mark = '{3'b100, 3'b010, 3'b000, 3'b011};
        rst = 1'b1;
        start = 1'b0; continuous = 1'b0; abort = 1'b0; start2 = 1'b0;
        auto_pop = 1'b1; pop_man = 1'b0; pop2 = 1'b0;
        bus.src_empty = 1'b0;
        bus.src_data = BASE;
        bus2.src_empty = 1'b1;
        bus2.src_data = 32'h0000_1234;
        clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_credit_err();
        test_credit_stall();
        test_starvation();
        test_continuous();
        test_abort();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
